// File: rtl/de_hazard_sb_pkg.sv
// Decode-stage shared definitions: datapath defaults, RV32 opcode/funct3
// constants and the instruction-class encoding used around the decoder.
package de_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        IT_R = 3'd0,
        IT_I = 3'd1,
        IT_S = 3'd2,
        IT_B = 3'd3,
        IT_U = 3'd4,
        IT_J = 3'd5
    } inst_type_e;

endpackage

// File: rtl/de_byp_mux.sv
// One source operand: prioritised bypass select (channel 0 wins) and the
// RAW-hazard bit for that source.
module de_byp_mux #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_BYP = 2
) (
    input  logic                      en,
    input  logic [REG_AW-1:0]         addr,
    input  logic [XLEN-1:0]           rd_data,
    input  logic                      pend_nz,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP*REG_AW-1:0] byp_addr,
    input  logic [NUM_BYP*XLEN-1:0]   byp_data,
    output logic [XLEN-1:0]           op,
    output logic                      haz
);

    logic hit;

    always_comb begin
        op  = rd_data;
        hit = 1'b0;
        // Walk oldest to youngest so the lowest matching index is the last write.
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (byp_valid[i] && byp_addr[i*REG_AW +: REG_AW] == addr) begin
                op  = byp_data[i*XLEN +: XLEN];
                hit = 1'b1;
            end
        end
        if (!en || addr == '0) begin
            op  = '0;
            hit = 1'b0;
        end
        haz = en && (addr != '0) && pend_nz && !hit;
    end

endmodule

// File: rtl/de_hazard_sb.sv
// Decode hazard scoreboard: per-register saturating pending-write counters,
// operand forwarding and the decode stall toward ctrl.
module de_hazard_sb
    import de_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_BYP = 2,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_rd_en,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      rs1_en,
    input  logic                      rs2_en,
    input  logic [REG_AW-1:0]         rs1,
    input  logic [REG_AW-1:0]         rs2,
    input  logic [XLEN-1:0]           rd_data1,
    input  logic [XLEN-1:0]           rd_data2,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP*REG_AW-1:0] byp_addr,
    input  logic [NUM_BYP*XLEN-1:0]   byp_data,
    input  logic                      retire_valid,
    input  logic [REG_AW-1:0]         retire_rd,
    output logic [XLEN-1:0]           op1_fwd,
    output logic [XLEN-1:0]           op2_fwd,
    output logic                      de_stall,
    output logic                      issue_fire,
    output logic                      sb_err
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pend [NREG];

    logic [1:0]             src_en, src_pend, src_haz;
    logic [1:0][REG_AW-1:0] src_addr;
    logic [1:0][XLEN-1:0]   src_rd, src_op;

    assign src_en   = {rs2_en, rs1_en};
    assign src_addr = {rs2, rs1};
    assign src_rd   = {rd_data2, rd_data1};
    assign src_pend = {pend[rs2] != '0, pend[rs1] != '0};

    for (genvar s = 0; s < 2; s++) begin : g_src
        de_byp_mux #(
            .XLEN    (XLEN),
            .REG_AW  (REG_AW),
            .NUM_BYP (NUM_BYP)
        ) u_mux (
            .en        (src_en[s]),
            .addr      (src_addr[s]),
            .rd_data   (src_rd[s]),
            .pend_nz   (src_pend[s]),
            .byp_valid (byp_valid),
            .byp_addr  (byp_addr),
            .byp_data  (byp_data),
            .op        (src_op[s]),
            .haz       (src_haz[s])
        );
    end

    assign op1_fwd = src_op[0];
    assign op2_fwd = src_op[1];

    logic sat;
    // A same-cycle retire of the destination frees the slot the new issue takes.
    assign sat = issue_rd_en && (issue_rd != '0) && (pend[issue_rd] == CNT_MAX)
                 && !(retire_valid && retire_rd == issue_rd);

    assign de_stall   = issue_valid && (src_haz[0] || src_haz[1] || sat);
    assign issue_fire = issue_valid && !de_stall;

    logic [NREG-1:0] inc, dec;
    logic            err_set;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r] = issue_fire && issue_rd_en && (issue_rd == REG_AW'(r));
            dec[r] = retire_valid && (retire_rd == REG_AW'(r)) && (pend[r] != '0);
        end
        err_set = retire_valid && (retire_rd != '0) && (pend[retire_rd] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
            sb_err <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r])      pend[r] <= pend[r] + 1'b1;
                else if (dec[r] && !inc[r]) pend[r] <= pend[r] - 1'b1;
            end
            if (err_set) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_de_hazard_sb.sv
// Directed bench for de_hazard_sb: RAW stall, bypass priority, saturation,
// x0 handling, flush/sb_err and asynchronous reset.
module tb_de_hazard_sb;

    localparam int XLEN = 32, REG_AW = 5, NUM_BYP = 2, CNT_W = 2;

    logic                      clk = 1'b0;
    logic                      rst, flush, issue_valid, issue_rd_en;
    logic [REG_AW-1:0]         issue_rd, rs1, rs2, retire_rd;
    logic                      rs1_en, rs2_en, retire_valid;
    logic [XLEN-1:0]           rd_data1, rd_data2;
    logic [NUM_BYP-1:0]        byp_valid;
    logic [NUM_BYP*REG_AW-1:0] byp_addr;
    logic [NUM_BYP*XLEN-1:0]   byp_data;
    logic [XLEN-1:0]           op1_fwd, op2_fwd;
    logic                      de_stall, issue_fire, sb_err;

    int vectors = 0;
    int miscompares = 0;

    de_hazard_sb #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_BYP(NUM_BYP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1(rs1), .rs2(rs2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .op1_fwd(op1_fwd), .op2_fwd(op2_fwd),
        .de_stall(de_stall), .issue_fire(issue_fire), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush = 0; issue_valid = 0; issue_rd_en = 0; issue_rd = 0;
        rs1_en = 0; rs2_en = 0; rs1 = 0; rs2 = 0;
        rd_data1 = 32'h1111_1111; rd_data2 = 32'h2222_2222;
        byp_valid = 0; byp_addr = 0; byp_data = 0;
        retire_valid = 0; retire_rd = 0;
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [REG_AW-1:0] rd);
        idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = rd; #1;
        vectors++;
        if (issue_fire !== 1'b1) begin
            miscompares++; $display("FAIL issue_fire_x%0d: got %b want 1", rd, issue_fire);
        end
        step();
    endtask

    task automatic retire(input logic [REG_AW-1:0] rd);
        idle(); retire_valid = 1; retire_rd = rd; step(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; #1;
        vectors++;
        if ({de_stall, issue_fire, sb_err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_outs: got %b want 000", {de_stall, issue_fire, sb_err});
        end
        vectors++;
        if (op1_fwd !== 32'h0) begin
            miscompares++; $display("FAIL reset_op1_disabled: got %h want 0", op1_fwd);
        end
        step(); rst = 0; step();
    endtask

    task automatic test_raw();
        issue(5);
        idle(); issue_valid = 1; rs1_en = 1; rs1 = 5; rd_data1 = 32'h1234; #1;
        vectors++;
        if ({de_stall, issue_fire} !== 2'b10) begin
            miscompares++; $display("FAIL raw_stall: got %b want 10", {de_stall, issue_fire});
        end
        step();
        retire_valid = 1; retire_rd = 5; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL raw_stall_retire_cycle: got %b want 1", de_stall);
        end
        step();
        retire_valid = 0; #1;
        vectors++;
        if ({de_stall, issue_fire} !== 2'b01) begin
            miscompares++; $display("FAIL raw_release: got %b want 01", {de_stall, issue_fire});
        end
        vectors++;
        if (op1_fwd !== 32'h1234) begin
            miscompares++; $display("FAIL raw_rf_op: got %h want 00001234", op1_fwd);
        end
        vectors++;
        if (sb_err !== 1'b0) begin
            miscompares++; $display("FAIL raw_no_err: got %b want 0", sb_err);
        end
        idle(); step();
    endtask

    task automatic test_bypass();
        issue(7);
        idle(); issue_valid = 1; rs1_en = 1; rs1 = 7;
        byp_valid = 2'b11; byp_addr = {5'd7, 5'd7}; byp_data = {32'hBBBB, 32'hAAAA}; #1;
        vectors++;
        if (op1_fwd !== 32'hAAAA || de_stall !== 1'b0) begin
            miscompares++; $display("FAIL byp_prio: got %h/%b want 0000aaaa/0", op1_fwd, de_stall);
        end
        byp_valid = 2'b10; #1;
        vectors++;
        if (op1_fwd !== 32'hBBBB || de_stall !== 1'b0) begin
            miscompares++; $display("FAIL byp_ch1: got %h/%b want 0000bbbb/0", op1_fwd, de_stall);
        end
        rs2_en = 1; rs2 = 3; byp_valid = 2'b11; byp_addr = {5'd7, 5'd3}; #1;
        vectors++;
        if (op1_fwd !== 32'hBBBB || op2_fwd !== 32'hAAAA) begin
            miscompares++; $display("FAIL byp_split: got %h/%h want 0000bbbb/0000aaaa", op1_fwd, op2_fwd);
        end
        step();
        // Bypass seen last cycle must not have cleared the pending count.
        byp_valid = 2'b00; rs2_en = 0; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL byp_keeps_pend: got %b want 1", de_stall);
        end
        retire(7);
    endtask

    task automatic test_saturation();
        issue(3); issue(3); issue(3);
        idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 3; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL sat_stall: got %b want 1", de_stall);
        end
        retire_valid = 1; retire_rd = 3; #1;
        vectors++;
        if ({de_stall, issue_fire} !== 2'b01) begin
            miscompares++; $display("FAIL sat_retire_frees: got %b want 01", {de_stall, issue_fire});
        end
        step();
        retire_valid = 0; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL sat_still_full: got %b want 1", de_stall);
        end
        retire(3); retire(3);
        idle(); issue_valid = 1; issue_rd_en = 1; issue_rd = 3; rs1_en = 1; rs1 = 3; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL sat_one_left: got %b want 1", de_stall);
        end
        retire(3);
        issue_valid = 1; rs1_en = 1; rs1 = 3; #1;
        vectors++;
        if (de_stall !== 1'b0) begin
            miscompares++; $display("FAIL sat_drained: got %b want 0", de_stall);
        end
        idle();
    endtask

    task automatic test_x0();
        idle(); issue_valid = 1; rs1_en = 1; rs2_en = 1; rs1 = 0; rs2 = 0;
        byp_valid = 2'b01; byp_addr = 0; byp_data = {32'h0, 32'hDEAD}; #1;
        vectors++;
        if (op1_fwd !== 32'h0 || op2_fwd !== 32'h0 || de_stall !== 1'b0) begin
            miscompares++; $display("FAIL x0_ops: got %h/%h/%b want 0/0/0", op1_fwd, op2_fwd, de_stall);
        end
        for (int k = 0; k < 4; k++) issue(0);
        retire(0);
        vectors++;
        if (sb_err !== 1'b0) begin
            miscompares++; $display("FAIL x0_retire_no_err: got %b want 0", sb_err);
        end
        issue_valid = 1; issue_rd_en = 1; issue_rd = 0; #1;
        vectors++;
        if (de_stall !== 1'b0) begin
            miscompares++; $display("FAIL x0_no_sat: got %b want 0", de_stall);
        end
        idle();
    endtask

    task automatic test_flush();
        issue(4); issue(4); issue(9);
        idle(); flush = 1; retire_valid = 1; retire_rd = 4; issue_valid = 1; rs1_en = 1; rs1 = 4; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL flush_comb_stall: got %b want 1", de_stall);
        end
        step();
        idle(); issue_valid = 1; rs1_en = 1; rs1 = 4; rs2_en = 1; rs2 = 9; #1;
        vectors++;
        if ({de_stall, sb_err} !== 2'b00) begin
            miscompares++; $display("FAIL flush_cleared: got %b want 00", {de_stall, sb_err});
        end
        retire(4);
        vectors++;
        if (sb_err !== 1'b1) begin
            miscompares++; $display("FAIL err_set: got %b want 1", sb_err);
        end
        step(); step();
        vectors++;
        if (sb_err !== 1'b1) begin
            miscompares++; $display("FAIL err_sticky: got %b want 1", sb_err);
        end
    endtask

    task automatic test_reset_mid();
        issue(6);
        idle(); issue_valid = 1; rs1_en = 1; rs1 = 6; #1;
        vectors++;
        if (de_stall !== 1'b1) begin
            miscompares++; $display("FAIL mid_pre_stall: got %b want 1", de_stall);
        end
        #1 rst = 1; #1;
        vectors++;
        if ({de_stall, issue_fire, sb_err} !== 3'b010) begin
            miscompares++; $display("FAIL mid_async_clear: got %b want 010", {de_stall, issue_fire, sb_err});
        end
        step(); rst = 0; step();
        vectors++;
        if (de_stall !== 1'b0) begin
            miscompares++; $display("FAIL mid_after_release: got %b want 0", de_stall);
        end
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_raw();
        test_bypass();
        test_saturation();
        test_x0();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
